// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - shared types and helpers for the instruction buffer
package idu_pkg;

  localparam int PARCEL_W = 16;

  typedef struct packed {
    logic [PARCEL_W-1:0] data;
    logic                err;
  } parcel_t;

  function automatic logic is_rvc(input logic [15:0] p);
    return p[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/idu_inst_buf_if.sv
// rtl/idu_inst_buf_if.sv - fetch-side and decode-side handshake bundle
interface idu_inst_buf_if #(
  parameter int FETCH_W = 32,
  parameter int PC_W    = 32
);
  logic               flush;
  logic [PC_W-1:0]    flush_pc;
  logic               fetch_valid;
  logic               fetch_ready;
  logic [FETCH_W-1:0] fetch_data;
  logic               fetch_err;
  logic               inst_valid;
  logic               inst_ready;
  logic [31:0]        inst;
  logic [PC_W-1:0]    inst_pc;
  logic               inst_rvc;
  logic               inst_err;

  modport master (
    output flush, flush_pc, fetch_valid, fetch_data, fetch_err, inst_ready,
    input  fetch_ready, inst_valid, inst, inst_pc, inst_rvc, inst_err
  );

  modport slave (
    input  flush, flush_pc, fetch_valid, fetch_data, fetch_err, inst_ready,
    output fetch_ready, inst_valid, inst, inst_pc, inst_rvc, inst_err
  );
endinterface

// File: rtl/idu_parcel_ram.sv
// rtl/idu_parcel_ram.sv - parcel storage with NP write lanes and two async read ports
module idu_parcel_ram
  import idu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NP    = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic [NP-1:0]          wr_en,
  input  logic [NP-1:0][AW-1:0]  wr_addr,
  input  parcel_t [NP-1:0]       wr_data,
  input  logic [AW-1:0]          rd_addr0,
  input  logic [AW-1:0]          rd_addr1,
  output parcel_t                rd_data0,
  output parcel_t                rd_data1
);

  parcel_t mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < NP; l++) begin
      if (wr_en[l]) mem[wr_addr[l]] <= wr_data[l];
    end
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/idu_inst_buf.sv
// rtl/idu_inst_buf.sv - parcel queue that realigns fetch words into one instruction per cycle
module idu_inst_buf
  import idu_pkg::*;
#(
  parameter int              FETCH_W  = 32,
  parameter int              DEPTH    = 8,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  idu_inst_buf_if.slave bus
);

  localparam int NP = FETCH_W / PARCEL_W;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(NP);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d, push_n, pop_n;
  logic [PC_W-1:0] rd_pc_q, rd_pc_d;
  logic [SW-1:0]   skip_q, skip_d;
  logic            push, pop, rvc, valid, space_ok;

  logic [NP-1:0]         wr_en;
  logic [NP-1:0][AW-1:0] wr_addr;
  parcel_t [NP-1:0]      wr_data;
  parcel_t               rd0, rd1;

  idu_parcel_ram #(.DEPTH(DEPTH), .NP(NP), .AW(AW)) u_ram (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_ptr_q),
    .rd_addr1 (rd_ptr_q + AW'(1)),
    .rd_data0 (rd0),
    .rd_data1 (rd1)
  );

  // Space check uses registered count only, so a same-cycle pop never frees room.
  always_comb begin
    rvc      = is_rvc(rd0.data);
    valid    = rvc ? (cnt_q >= CW'(1)) : (cnt_q >= CW'(2));
    space_ok = (CW'(DEPTH) - cnt_q) >= CW'(NP);
    push     = bus.fetch_valid && space_ok && !bus.flush;
    pop      = valid && bus.inst_ready && !bus.flush;
    push_n   = push ? (CW'(NP) - CW'(skip_q)) : '0;
    pop_n    = pop ? (rvc ? CW'(1) : CW'(2)) : '0;
  end

  // Parcels below skip belong to addresses before the redirect target and are dropped.
  always_comb begin
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int j = 0; j < NP; j++) begin
      wr_en[j]        = push && (SW'(j) >= skip_q);
      wr_addr[j]      = wr_ptr_q + AW'(j) - AW'(skip_q);
      wr_data[j].data = bus.fetch_data[j*PARCEL_W +: PARCEL_W];
      wr_data[j].err  = bus.fetch_err;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rd_pc_d  = rd_pc_q;
    skip_d   = skip_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      rd_pc_d  = bus.flush_pc;
      skip_d   = bus.flush_pc[SW:1];
    end else begin
      wr_ptr_d = wr_ptr_q + push_n[AW-1:0];
      rd_ptr_d = rd_ptr_q + pop_n[AW-1:0];
      cnt_d    = cnt_q + push_n - pop_n;
      rd_pc_d  = rd_pc_q + (PC_W'(pop_n) << 1);
      if (push) skip_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rd_pc_q  <= RESET_PC;
      skip_q   <= RESET_PC[SW:1];
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rd_pc_q  <= rd_pc_d;
      skip_q   <= skip_d;
    end
  end

  always_comb begin
    bus.fetch_ready = space_ok;
    bus.inst_valid  = valid;
    bus.inst_rvc    = valid && rvc;
    bus.inst_err    = valid && (rd0.err || (!rvc && rd1.err));
    bus.inst_pc     = rd_pc_q;
    bus.inst        = '0;
    if (valid) bus.inst = rvc ? {16'h0, rd0.data} : {rd1.data, rd0.data};
  end

  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    (cnt_q <= CW'(DEPTH)) && (pop_n <= cnt_q));

endmodule

// File: tb/tb_idu_inst_buf.sv
// tb/tb_idu_inst_buf.sv - scoreboard bench for 32-bit and 64-bit instruction buffer instances
module tb_idu_inst_buf;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        rvc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  idu_inst_buf_if #(.FETCH_W(32), .PC_W(32)) b32 ();
  idu_inst_buf_if #(.FETCH_W(64), .PC_W(32)) b64 ();

  idu_inst_buf #(.FETCH_W(32), .DEPTH(8), .PC_W(32), .RESET_PC(32'h0)) u32 (
    .clk (clk), .rst (rst), .bus (b32)
  );

  idu_inst_buf #(.FETCH_W(64), .DEPTH(16), .PC_W(32), .RESET_PC(32'h1004)) u64 (
    .clk (clk), .rst (rst), .bus (b64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p,
                              input logic r, input logic er);
    exp_t e;
    e.inst = i; e.pc = p; e.rvc = r; e.err = er;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && !b32.flush && b32.inst_valid && b32.inst_ready) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb32_unexpected: got inst %0h pc %0h expected none", b32.inst, b32.inst_pc);
      end else begin
        e32 = q32.pop_front();
        chk("sb32_inst", b32.inst, e32.inst);
        chk("sb32_pc", b32.inst_pc, e32.pc);
        chk("sb32_rvc", b32.inst_rvc, e32.rvc);
        chk("sb32_err", b32.inst_err, e32.err);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !b64.flush && b64.inst_valid && b64.inst_ready) begin
      if (q64.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb64_unexpected: got inst %0h pc %0h expected none", b64.inst, b64.inst_pc);
      end else begin
        e64 = q64.pop_front();
        chk("sb64_inst", b64.inst, e64.inst);
        chk("sb64_pc", b64.inst_pc, e64.pc);
        chk("sb64_rvc", b64.inst_rvc, e64.rvc);
        chk("sb64_err", b64.inst_err, e64.err);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push32(input logic [31:0] d, input logic e);
    b32.fetch_valid = 1'b1; b32.fetch_data = d; b32.fetch_err = e;
    for (int n = 0; n < 100 && !b32.fetch_ready; n++) begin b32.inst_ready = 1'b1; tick(1); end
    chk("push32_ready", b32.fetch_ready, 1);
    tick(1);
    b32.fetch_valid = 1'b0;
  endtask

  task automatic push64(input logic [63:0] d, input logic e);
    b64.fetch_valid = 1'b1; b64.fetch_data = d; b64.fetch_err = e;
    for (int n = 0; n < 100 && !b64.fetch_ready; n++) begin b64.inst_ready = 1'b1; tick(1); end
    chk("push64_ready", b64.fetch_ready, 1);
    tick(1);
    b64.fetch_valid = 1'b0;
  endtask

  task automatic drain32();
    for (int n = 0; n < 100 && q32.size() != 0; n++) tick(1);
    chk("drain32_left", q32.size(), 0);
    tick(2);
  endtask

  task automatic drain64();
    for (int n = 0; n < 300 && q64.size() != 0; n++) tick(1);
    chk("drain64_left", q64.size(), 0);
    tick(2);
  endtask

  task automatic run64();
    logic [15:0] par[$];
    logic        werr [16];
    logic [31:0] hi;
    logic [15:0] lo;
    int          i;
    par.push_back(16'h0093);
    par.push_back(16'hffff);
    for (int w = 0; w < 16; w++) werr[w] = ($urandom_range(0, 3) == 0);
    while (par.size() < 40) begin
      i  = par.size();
      hi = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        lo = {hi[15:2], 2'($urandom_range(0, 2))};
        q64.push_back(mk({16'h0, lo}, 32'h1000 + 32'(2*i), 1'b1, werr[i/4]));
        par.push_back(lo);
      end else begin
        q64.push_back(mk({hi[31:2], 2'b11}, 32'h1000 + 32'(2*i), 1'b0,
                         werr[i/4] | werr[(i+1)/4]));
        par.push_back({hi[15:2], 2'b11});
        par.push_back(hi[31:16]);
      end
    end
    while (par.size() % 4 != 0) begin
      i = par.size();
      q64.push_back(mk(32'h1, 32'h1000 + 32'(2*i), 1'b1, werr[i/4]));
      par.push_back(16'h0001);
    end
    for (int w = 0; w < par.size() / 4; w++) begin
      b64.inst_ready = 1'($urandom_range(0, 1));
      push64({par[4*w+3], par[4*w+2], par[4*w+1], par[4*w]}, werr[w]);
    end
    b64.inst_ready = 1'b1;
    drain64();
  endtask

  initial begin
    rst = 1'b1;
    b32.flush = 0; b32.flush_pc = '0; b32.fetch_valid = 0; b32.fetch_data = '0;
    b32.fetch_err = 0; b32.inst_ready = 0;
    b64.flush = 0; b64.flush_pc = '0; b64.fetch_valid = 0; b64.fetch_data = '0;
    b64.fetch_err = 0; b64.inst_ready = 0;
    tick(3);
    rst = 1'b0;
    chk("rst32_valid", b32.inst_valid, 0);
    chk("rst32_fready", b32.fetch_ready, 1);
    chk("rst32_inst", b32.inst, 0);
    chk("rst32_rvc", b32.inst_rvc, 0);
    chk("rst32_err", b32.inst_err, 0);
    chk("rst32_pc", b32.inst_pc, 32'h0);
    chk("rst64_pc", b64.inst_pc, 32'h1004);
    chk("rst64_fready", b64.fetch_ready, 1);

    // Single 32-bit instruction.
    b32.inst_ready = 1'b1;
    q32.push_back(mk(32'h00130093, 32'h0, 1'b0, 1'b0));
    push32(32'h00130093, 1'b0);
    chk("t1_valid_next", b32.inst_valid, 1);
    drain32();

    // Two compressed instructions in one word.
    q32.push_back(mk(32'h00004501, 32'h4, 1'b1, 1'b0));
    q32.push_back(mk(32'h00004505, 32'h6, 1'b1, 1'b0));
    push32(32'h45054501, 1'b0);
    drain32();

    // 32-bit instruction straddling two fetch words; second word faulted.
    q32.push_back(mk(32'h00004501, 32'h8, 1'b1, 1'b0));
    q32.push_back(mk(32'h00130093, 32'ha, 1'b0, 1'b1));
    push32(32'h00934501, 1'b0);
    tick(3);
    chk("t3_half_not_valid", b32.inst_valid, 0);
    q32.push_back(mk(32'h00004581, 32'he, 1'b1, 1'b1));
    push32(32'h45810013, 1'b1);
    drain32();

    // Fill to full across the pointer wrap, then drain.
    q32.push_back(mk(32'h00004501, 32'h10, 1'b1, 1'b0));
    q32.push_back(mk(32'h00004505, 32'h12, 1'b1, 1'b0));
    push32(32'h45054501, 1'b0);
    drain32();
    b32.inst_ready = 1'b0;
    q32.push_back(mk(32'h00100093, 32'h14, 1'b0, 1'b0));
    q32.push_back(mk(32'h00200113, 32'h18, 1'b0, 1'b0));
    q32.push_back(mk(32'h00300193, 32'h1c, 1'b0, 1'b0));
    q32.push_back(mk(32'h00400213, 32'h20, 1'b0, 1'b0));
    push32(32'h00100093, 1'b0);
    push32(32'h00200113, 1'b0);
    push32(32'h00300193, 1'b0);
    push32(32'h00400213, 1'b0);
    chk("t4_full_fready", b32.fetch_ready, 0);
    tick(3);
    chk("t4_hold_valid", b32.inst_valid, 1);
    chk("t4_hold_inst", b32.inst, 32'h00100093);
    chk("t4_hold_pc", b32.inst_pc, 32'h14);
    b32.inst_ready = 1'b1;
    drain32();

    // Flush with push and pop both active, misaligned redirect.
    b32.inst_ready = 1'b0;
    push32(32'h45054501, 1'b0);
    b32.flush = 1'b1; b32.flush_pc = 32'h80000002;
    b32.fetch_valid = 1'b1; b32.fetch_data = 32'h00130093; b32.inst_ready = 1'b1;
    tick(1);
    b32.flush = 1'b0; b32.fetch_valid = 1'b0;
    chk("t5_valid", b32.inst_valid, 0);
    chk("t5_fready", b32.fetch_ready, 1);
    chk("t5_pc", b32.inst_pc, 32'h80000002);
    tick(2);
    chk("t5_still_empty", b32.inst_valid, 0);
    q32.push_back(mk(32'h00004505, 32'h80000002, 1'b1, 1'b0));
    q32.push_back(mk(32'h00130093, 32'h80000004, 1'b0, 1'b0));
    push32(32'h45050093, 1'b0);
    push32(32'h00130093, 1'b0);
    drain32();

    // 64-bit instance: mixed stream, then reset with data buffered.
    run64();
    b64.inst_ready = 1'b0;
    push64(64'h0013009300130093, 1'b1);
    push64(64'h4505450145054501, 1'b0);
    chk("t6_pre_rst_valid", b64.inst_valid, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", b64.inst_valid, 0);
    chk("t6_rst_fready", b64.fetch_ready, 1);
    chk("t6_rst_inst", b64.inst, 0);
    chk("t6_rst_rvc", b64.inst_rvc, 0);
    chk("t6_rst_err", b64.inst_err, 0);
    chk("t6_rst_pc", b64.inst_pc, 32'h1004);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("t6_post_rst_valid", b64.inst_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
